memstream_cfg_master: RTL and testbench

Command-driven initiator for the ap_memory-style config port of a streaming weight memory. A LOAD command writes an input stream into consecutive memory words. A DUMP command reads consecutive words back and emits them as a backpressured output stream. The block sits between a host/DMA stream and the memory's config port. It hides the fixed-latency, non-stallable readback path behind a credit-limited FIFO.

---
 rtl/memstream_cfg_master.sv | 206 ++++++++++++++++++++
 tb/tb_memstream_cfg_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memstream_cfg_master.sv
// memstream_cfg_master
// Command-driven initiator for an ap_memory-style config port. LOAD streams
// input words into consecutive memory addresses; DUMP reads consecutive
// addresses back and presents them as a backpressured stream. The readback
// path cannot stall, so reads are throttled by credits that are only returned
// when the downstream consumer accepts a word. The FIFO therefore never
// overflows.
module memstream_cfg_master #(
  parameter int  DEPTH      = 1024,
  parameter int  WIDTH      = 32,
  parameter int  CREDITS    = 4,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // command channel
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  // LOAD input stream
  input  logic [WIDTH-1:0]      idat,
  input  logic                  ivld,
  output logic                  irdy,
  // DUMP output stream
  output logic [WIDTH-1:0]      odat,
  output logic                  ovld,
  input  logic                  ordy,
  // memory config port
  output logic                  config_ce,
  output logic                  config_we,
  output logic [ADDR_WIDTH-1:0] config_address,
  output logic [WIDTH-1:0]      config_d0,
  input  logic                  config_rack,
  input  logic [WIDTH-1:0]      config_q0,
  // status
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(CREDITS + 1);               // credit / occupancy width
  localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1; // FIFO pointer width

  localparam logic [CW-1:0]         CREDITS_C = CW'(CREDITS);
  localparam logic [PW-1:0]         FIFO_LAST = PW'(CREDITS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [CW-1:0]         r_credit;
  logic [CW-1:0]         r_outst;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [WIDTH-1:0]      r_fifo [CREDITS];
  logic                  r_ce;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_d0;
  logic                  r_ovld;
  logic                  r_done;

  logic                  w_cmd_fire;
  logic                  w_beat;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rem_last;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic [CW-1:0]         w_credit_next;
  logic [CW-1:0]         w_outst_next;
  logic [CW-1:0]         w_count_next;

  assign cmd_rdy = (r_state == S_IDLE);
  assign irdy    = (r_state == S_LOAD) && (r_rem != '0);
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

  assign config_ce      = r_ce;
  assign config_we      = r_we;
  assign config_address = r_addr;
  assign config_d0      = r_d0;

  assign ovld = r_ovld;
  assign odat = r_fifo[r_rd_ptr];

  assign w_cmd_fire = cmd_vld && (r_state == S_IDLE);
  assign w_beat     = irdy && ivld;
  assign w_issue    = (r_state == S_DUMP) && (r_rem != '0) && (r_credit < CREDITS_C);
  // Racks with nothing outstanding (e.g. left over from an aborted command) are ignored.
  assign w_push     = config_rack && (r_outst != '0);
  assign w_pop      = r_ovld && ordy;
  assign w_rem_last = (r_rem == REM_ONE);
  // Explicit wrap so non-power-of-two depths stay in range.
  assign w_ptr_next = (r_ptr == ADDR_LAST) ? '0 : r_ptr + 1'b1;

  // Next values of the credit, outstanding-read and FIFO-occupancy counters.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_credit_next = r_credit;
    w_outst_next  = r_outst;
    w_count_next  = r_count;
    if (w_issue && !w_pop) w_credit_next = r_credit + 1'b1;
    if (!w_issue && w_pop) w_credit_next = r_credit - 1'b1;
    if (w_issue && !w_push) w_outst_next = r_outst + 1'b1;
    if (!w_issue && w_push) w_outst_next = r_outst - 1'b1;
    if (w_push && !w_pop)  w_count_next = r_count + 1'b1;
    if (!w_push && w_pop)  w_count_next = r_count - 1'b1;
  end

  // Control FSM and the one-cycle done pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_len == '0) r_done  <= 1'b1;
            else               r_state <= cmd_op ? S_DUMP : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_beat && w_rem_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_DUMP: begin
          if (w_issue && w_rem_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_outst == '0) && (r_count == '0)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Address pointer and remaining-word count for the active command.
  always_ff @(posedge clk) begin
    if (w_cmd_fire) begin
      r_ptr <= cmd_base;
      r_rem <= cmd_len;
    end else if (w_beat || w_issue) begin
      r_ptr <= w_ptr_next;
      r_rem <= r_rem - 1'b1;
    end
  end

  // Registered config-port strobes: one cycle per write beat or issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce <= 1'b0;
      r_we <= 1'b0;
    end else begin
      r_ce <= w_beat || w_issue;
      r_we <= w_beat;
    end
  end

  // Config-port address and write data; only meaningful while config_ce is high.
  always_ff @(posedge clk) begin
    if (w_beat || w_issue) r_addr <= r_ptr;
    if (w_beat)            r_d0   <= idat;
  end

  // Credit, outstanding-read and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
      r_outst  <= '0;
      r_count  <= '0;
      r_ovld   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_credit <= w_credit_next;
      r_outst  <= w_outst_next;
      r_count  <= w_count_next;
      r_ovld   <= (w_count_next != '0);
      if (w_push) r_wr_ptr <= (r_wr_ptr == FIFO_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == FIFO_LAST) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Readback FIFO storage.
  // NOTE: storage is not reset; the cleared pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= config_q0;
  end

endmodule

// File: tb/tb_memstream_cfg_master.sv
// Testbench for memstream_cfg_master. Two instances: DEPTH=16 (dev 0) and
// DEPTH=10 (dev 1, address wrap), each with a 3-cycle-latency responder.
// Commands come from a vector table; reset-mid-DUMP is a hand sequence.
module tb_memstream_cfg_master;

  localparam int WIDTH   = 32;
  localparam int CREDITS = 4;
  localparam int AW      = 4;   // both depths (16 and 10) need 4 address bits

  typedef struct {
    string       name;
    int          dev;
    bit          op;            // 0 LOAD, 1 DUMP
    int          base;
    int          len;
    logic [31:0] seed;          // LOAD word i = seed + i
    int          lo;            // ordy held low for cycles lo..hi after handshake
    int          hi;
    int          exp_first_ce;  // -1: no config access expected
    int          exp_first_ovld;
    int          exp_done;      // -1: not checked
    int          exp_max_if;    // peak reads issued but not yet accepted downstream
  } vec_t;

  logic clk;
  logic rst;
  logic             cmd_vld [2];
  logic             cmd_rdy [2];
  logic             cmd_op  [2];
  logic [AW-1:0]    cmd_base[2];
  logic [AW:0]      cmd_len [2];
  logic [WIDTH-1:0] idat    [2];
  logic             ivld    [2];
  logic             irdy    [2];
  logic [WIDTH-1:0] odat    [2];
  logic             ovld    [2];
  logic             ordy    [2];
  logic             config_ce     [2];
  logic             config_we     [2];
  logic [AW-1:0]    config_address[2];
  logic [WIDTH-1:0] config_d0     [2];
  logic             config_rack   [2];
  logic [WIDTH-1:0] config_q0     [2];
  logic             busy [2];
  logic             done [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_mem [2][16];   // expected memory contents, from driven LOAD data
  logic [31:0] rmem    [2][16];   // responder memory, written by the DUT
  logic        p_v     [2][3];
  logic [31:0] p_d     [2][3];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    memstream_cfg_master #(.DEPTH(g == 0 ? 16 : 10), .WIDTH(WIDTH), .CREDITS(CREDITS)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_vld(cmd_vld[g]), .cmd_rdy(cmd_rdy[g]), .cmd_op(cmd_op[g]),
      .cmd_base(cmd_base[g]), .cmd_len(cmd_len[g]),
      .idat(idat[g]), .ivld(ivld[g]), .irdy(irdy[g]),
      .odat(odat[g]), .ovld(ovld[g]), .ordy(ordy[g]),
      .config_ce(config_ce[g]), .config_we(config_we[g]),
      .config_address(config_address[g]), .config_d0(config_d0[g]),
      .config_rack(config_rack[g]), .config_q0(config_q0[g]),
      .busy(busy[g]), .done(done[g])
    );
    assign config_rack[g] = p_v[g][2];
    assign config_q0[g]   = p_d[g][2];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: read strobe seen in cycle t returns rack in cycle t+3. Not reset.
  initial begin
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 3; s++) begin
        p_v[d][s] = 1'b0;
        p_d[d][s] = '0;
      end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (config_ce[d] && config_we[d]) rmem[d][config_address[d]] <= config_d0[d];
      p_v[d][0] <= config_ce[d] && !config_we[d];
      p_d[d][0] <= rmem[d][config_address[d]];
      p_v[d][1] <= p_v[d][0];
      p_d[d][1] <= p_d[d][0];
      p_v[d][2] <= p_v[d][1];
      p_d[d][2] <= p_d[d][1];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 10;
  endfunction

  function automatic vec_t mk(input string name, input int dev, input bit op, input int base,
                              input int len, input logic [31:0] seed, input int lo, input int hi,
                              input int fce, input int fov, input int dn, input int mif);
    vec_t v;
    v.name = name; v.dev = dev; v.op = op; v.base = base; v.len = len; v.seed = seed;
    v.lo = lo; v.hi = hi; v.exp_first_ce = fce; v.exp_first_ovld = fov;
    v.exp_done = dn; v.exp_max_if = mif;
    return v;
  endfunction

  // Runs one command; cycle 0 is the handshake cycle. Outputs are sampled on
  // the falling edge, then the inputs for that cycle are driven.
  task automatic run_cmd(input vec_t v);
    int d, dep, k, beat, n_wr, n_rd, n_pop, first_ce, first_ovld, done_cyc, max_if, cur_if;
    bit fin, busy_seen, ordy_k;
    logic [31:0] exp_w;
    d = v.dev; dep = depth_of(d);
    k = 0; beat = 0; n_wr = 0; n_rd = 0; n_pop = 0;
    first_ce = -1; first_ovld = -1; done_cyc = -1; max_if = 0;
    fin = 1'b0; busy_seen = 1'b0;
    @(negedge clk);
    check({v.name, "/cmd_rdy_pre"}, 32'(cmd_rdy[d]), 32'd1);
    cmd_vld[d]  = 1'b1;
    cmd_op[d]   = v.op;
    cmd_base[d] = AW'(v.base);
    cmd_len[d]  = (AW + 1)'(v.len);
    ordy[d]     = 1'b1;
    ivld[d]     = 1'b0;
    while (!fin && k < 300) begin
      @(negedge clk);
      k++;
      cmd_vld[d] = 1'b0;
      if (config_ce[d]) begin
        if (first_ce < 0) first_ce = k;
        if (config_we[d]) begin
          check({v.name, "/wr_addr"}, 32'(config_address[d]), 32'((v.base + n_wr) % dep));
          check({v.name, "/wr_data"}, config_d0[d], v.seed + 32'(n_wr));
          n_wr++;
        end else begin
          check({v.name, "/rd_addr"}, 32'(config_address[d]), 32'((v.base + n_rd) % dep));
          n_rd++;
        end
      end
      if (busy[d]) busy_seen = 1'b1;
      cur_if = n_rd - n_pop;
      if (cur_if > max_if) max_if = cur_if;
      if (ovld[d] && first_ovld < 0) first_ovld = k;
      ordy_k  = !(k >= v.lo && k <= v.hi);
      ordy[d] = ordy_k;
      if (ovld[d] && ordy_k) begin
        exp_w = exp_mem[d][(v.base + n_pop) % dep];
        check({v.name, "/odat"}, odat[d], exp_w);
        n_pop++;
      end
      if (done[d]) begin
        done_cyc = k;
        fin = 1'b1;
      end
      if (v.op == 1'b0) begin
        ivld[d] = (beat < v.len);
        idat[d] = v.seed + 32'(beat);
        if (ivld[d] && irdy[d]) beat++;
      end
    end
    ivld[d] = 1'b0;
    check({v.name, "/done_seen"}, 32'(fin), 32'd1);
    if (v.exp_done >= 0) check({v.name, "/done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({v.name, "/first_ce"}, 32'(first_ce), 32'(v.exp_first_ce));
    check({v.name, "/first_ovld"}, 32'(first_ovld), 32'(v.exp_first_ovld));
    check({v.name, "/n_wr"}, 32'(n_wr), (v.op == 1'b0) ? 32'(v.len) : 32'd0);
    check({v.name, "/n_rd"}, 32'(n_rd), (v.op == 1'b1) ? 32'(v.len) : 32'd0);
    check({v.name, "/n_pop"}, 32'(n_pop), (v.op == 1'b1) ? 32'(v.len) : 32'd0);
    check({v.name, "/max_inflight"}, 32'(max_if), 32'(v.exp_max_if));
    check({v.name, "/busy_seen"}, 32'(busy_seen), 32'(v.len != 0));
    @(negedge clk);
    check({v.name, "/done_single"}, 32'(done[d]), 32'd0);
    check({v.name, "/cmd_rdy_post"}, 32'(cmd_rdy[d]), 32'd1);
    check({v.name, "/busy_post"}, 32'(busy[d]), 32'd0);
    if (v.op == 1'b0)
      for (int i = 0; i < v.len; i++) exp_mem[d][(v.base + i) % dep] = v.seed + 32'(i);
  endtask

  vec_t vecs [8];

  initial begin
    bit bad_ovld, bad_done;
    //               name        dev op base len seed    lo hi  ce  ovld done maxif
    vecs[0] = mk("load4",      0, 0, 0,   4, 32'hA0, 0, -1, 2,  -1,  5,  0);
    vecs[1] = mk("dump4",      0, 1, 0,   4, 32'h0,  0, -1, 2,   6,  11, 4);
    vecs[2] = mk("load12",     0, 0, 4,  12, 32'hB0, 0, -1, 2,  -1,  13, 0);
    vecs[3] = mk("dump12_bp",  0, 1, 2,  12, 32'h0,  4, 14, 2,   6,  -1, 4);
    vecs[4] = mk("load_wrap",  1, 0, 8,   4, 32'hC0, 0, -1, 2,  -1,  5,  0);
    vecs[5] = mk("dump_wrap",  1, 1, 8,   4, 32'h0,  0, -1, 2,   6,  11, 4);
    vecs[6] = mk("load_zero",  0, 0, 3,   0, 32'hD0, 0, -1, -1, -1,  1,  0);
    vecs[7] = mk("dump_zero",  0, 1, 3,   0, 32'h0,  0, -1, -1, -1,  1,  0);

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_vld[d] = 1'b0; cmd_op[d] = 1'b0; cmd_base[d] = '0; cmd_len[d] = '0;
      idat[d] = '0; ivld[d] = 1'b0; ordy[d] = 1'b1;
      for (int a = 0; a < 16; a++) exp_mem[d][a] = 'x;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Values straight out of reset.
    for (int d = 0; d < 2; d++) begin
      check("rst/cmd_rdy",   32'(cmd_rdy[d]),   32'd1);
      check("rst/irdy",      32'(irdy[d]),      32'd0);
      check("rst/ovld",      32'(ovld[d]),      32'd0);
      check("rst/config_ce", 32'(config_ce[d]), 32'd0);
      check("rst/config_we", 32'(config_we[d]), 32'd0);
      check("rst/busy",      32'(busy[d]),      32'd0);
      check("rst/done",      32'(done[d]),      32'd0);
    end

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Reset mid-DUMP: reads issued in cycles 1 and 2, reset taken at the end
    // of cycle 3, their racks arrive in cycles 5 and 6 and must be dropped.
    @(negedge clk);
    cmd_vld[0] = 1'b1; cmd_op[0] = 1'b1; cmd_base[0] = '0; cmd_len[0] = 5'd4; ordy[0] = 1'b1;
    @(negedge clk);
    cmd_vld[0] = 1'b0;
    @(negedge clk);
    check("rstdump/ce_c2", 32'(config_ce[0]), 32'd1);
    @(negedge clk);
    check("rstdump/ce_c3", 32'(config_ce[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstdump/ovld",    32'(ovld[0]),      32'd0);
    check("rstdump/cmd_rdy", 32'(cmd_rdy[0]),   32'd1);
    check("rstdump/busy",    32'(busy[0]),      32'd0);
    check("rstdump/ce",      32'(config_ce[0]), 32'd0);
    bad_ovld = 1'b0; bad_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ovld[0]) bad_ovld = 1'b1;
      if (done[0]) bad_done = 1'b1;
    end
    check("rstdump/late_rack_dropped", 32'(bad_ovld), 32'd0);
    check("rstdump/no_done",           32'(bad_done), 32'd0);
    run_cmd(mk("dump_after_rst", 0, 1, 0, 4, 32'h0, 0, -1, 2, 6, 11, 4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
